compliance_bus_arbiter: RTL

- N-to-1 request/grant bus arbiter for the compliance simulation top.
- Shares the single data-memory port between the core data host and the signature-dump host of the test-utility block; sits directly upstream of the RAM.
- Round-robin arbitration; address/data held stable while the device stalls.
- Responses are routed back in order through an index FIFO of outstanding transactions.

---
 rtl/compliance_bus_pkg.sv | 21 ++
 rtl/compliance_bus_arbiter_checker.sv | 45 ++++
 rtl/compliance_bus_idx_fifo.sv | 66 ++++++
 rtl/compliance_bus_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/compliance_bus_pkg.sv
// Shared bus types for the compliance simulation top: one request beat and one
// response beat of the single-port data-memory bus.
package compliance_bus_pkg;

    localparam int unsigned BusAddrW = 32;
    localparam int unsigned BusDataW = 32;
    localparam int unsigned BusBeW   = 4;

    typedef struct packed {
        logic                we;
        logic [BusBeW-1:0]   be;
        logic [BusAddrW-1:0] addr;
        logic [BusDataW-1:0] wdata;
    } bus_req_t;

    typedef struct packed {
        logic [BusDataW-1:0] rdata;
        logic                err;
    } bus_rsp_t;

endpackage

// File: rtl/compliance_bus_arbiter_checker.sv
// Simulation-only protocol checks for the arbiter: request held through a
// stall, stray responses, and index FIFO overflow.
module compliance_bus_arbiter_checker #(
    parameter int unsigned NrHosts = 2,
    parameter int unsigned IdxW    = 1
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic [NrHosts-1:0] host_req_i,
    input logic               stall_i,
    input logic [IdxW-1:0]    sel_i,
    input logic               dev_rvalid_i,
    input logic               fifo_empty_i,
    input logic               fifo_full_i,
    input logic               push_i,
    input logic               pop_i
);

    logic            stalled_r;
    logic [IdxW-1:0] stalled_idx_r;

    // Remember the stalled host so the following cycle can confirm it still requests
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stalled_r     <= 1'b0;
            stalled_idx_r <= '0;
        end else begin
            stalled_r     <= stall_i;
            stalled_idx_r <= sel_i;
        end
    end

    // Protocol checks, sampled on the active edge outside reset
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!stalled_r || host_req_i[stalled_idx_r])
                else $error("host %0d withdrew its request while stalled", stalled_idx_r);
            assert (!(dev_rvalid_i && fifo_empty_i))
                else $warning("stray response dropped: no outstanding transaction");
            assert (!(push_i && fifo_full_i && !pop_i))
                else $error("index fifo overflow");
        end
    end

endmodule

// File: rtl/compliance_bus_idx_fifo.sv
// Small synchronous FIFO holding the host index of every granted transaction
// still waiting for its in-order response.
module compliance_bus_idx_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;
    logic [CntW-1:0]  count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    assign full_o  = (count_r == CntW'(Depth));
    assign empty_o = (count_r == '0);
    assign count_o = count_r;
    assign data_o  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/compliance_bus_arbiter.sv
// Round-robin N-to-1 arbiter in front of the data RAM; the selection is locked
// while the RAM stalls and responses are routed back through an index FIFO.
module compliance_bus_arbiter
    import compliance_bus_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned IdxW           = $clog2(NrHosts)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrHosts-1:0]                 host_req_i,
    input  logic [NrHosts-1:0]                 host_we_i,
    input  logic [NrHosts-1:0][BusBeW-1:0]     host_be_i,
    input  logic [NrHosts-1:0][BusAddrW-1:0]   host_addr_i,
    input  logic [NrHosts-1:0][BusDataW-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]                 host_gnt_o,
    output logic [NrHosts-1:0]                 host_rvalid_o,
    output logic [BusDataW-1:0]                host_rdata_o,
    output logic [NrHosts-1:0]                 host_err_o,
    output logic                               dev_req_o,
    output logic                               dev_we_o,
    output logic [BusBeW-1:0]                  dev_be_o,
    output logic [BusAddrW-1:0]                dev_addr_o,
    output logic [BusDataW-1:0]                dev_wdata_o,
    input  logic                               dev_gnt_i,
    input  logic                               dev_rvalid_i,
    input  logic [BusDataW-1:0]                dev_rdata_i,
    input  logic                               dev_err_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] rr_ptr_r;
    logic            lock_r;
    logic [IdxW-1:0] locked_idx_r;
    logic [IdxW-1:0] rr_sel_s;
    logic [IdxW-1:0] sel_s;
    logic [IdxW-1:0] head_idx_s;
    logic            any_req_s;
    logic            can_issue_s;
    logic            grant_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CntW-1:0] fifo_count_s;
    bus_req_t        sel_req_s;
    bus_rsp_t        dev_rsp_s;

    // A response arriving this cycle frees its slot for a same-cycle issue.
    assign any_req_s   = |host_req_i;
    assign can_issue_s = (fifo_count_s < CntW'(MaxOutstanding)) | dev_rvalid_i;
    assign dev_req_o   = can_issue_s & any_req_s;
    assign grant_s     = dev_req_o & dev_gnt_i;
    assign pop_s       = dev_rvalid_i & ~fifo_empty_s;
    assign sel_s       = lock_r ? locked_idx_r : rr_sel_s;
    assign dev_rsp_s   = '{rdata: dev_rdata_i, err: dev_err_i};

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        logic [IdxW-1:0] cand;
        logic            found;
        rr_sel_s = rr_ptr_r;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            cand     = IdxW'((32'(rr_ptr_r) + i) % NrHosts);
            rr_sel_s = (!found && host_req_i[cand]) ? cand : rr_sel_s;
            found    = found | host_req_i[cand];
        end
    end

    // Round-robin pointer and stall lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r     <= '0;
            lock_r       <= 1'b0;
            locked_idx_r <= '0;
        end else begin
            if (grant_s) begin
                rr_ptr_r <= IdxW'((32'(sel_s) + 32'd1) % NrHosts);
            end
            if (dev_req_o && !dev_gnt_i) begin
                lock_r       <= 1'b1;
                locked_idx_r <= sel_s;
            end else if (dev_gnt_i) begin
                lock_r <= 1'b0;
            end
        end
    end

    // Request mux towards the RAM, zeroed when nothing is issued
    always_comb begin
        sel_req_s = '0;
        if (dev_req_o) begin
            sel_req_s.we    = host_we_i[sel_s];
            sel_req_s.be    = host_be_i[sel_s];
            sel_req_s.addr  = host_addr_i[sel_s];
            sel_req_s.wdata = host_wdata_i[sel_s];
        end else begin
            sel_req_s = '0;
        end
    end

    assign dev_we_o    = sel_req_s.we;
    assign dev_be_o    = sel_req_s.be;
    assign dev_addr_o  = sel_req_s.addr;
    assign dev_wdata_o = sel_req_s.wdata;

    // One-hot grant back to the selected host
    always_comb begin
        host_gnt_o = '0;
        if (grant_s) begin
            host_gnt_o[sel_s] = 1'b1;
        end else begin
            host_gnt_o = '0;
        end
    end

    // Response routing to the host at the FIFO head
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (pop_s) begin
            host_rvalid_o[head_idx_s] = 1'b1;
            host_err_o[head_idx_s]    = dev_rsp_s.err;
            host_rdata_o              = dev_rsp_s.rdata;
        end else begin
            host_rdata_o = '0;
        end
    end

    compliance_bus_idx_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant_s),
        .data_i  (sel_s),
        .pop_i   (pop_s),
        .data_o  (head_idx_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    compliance_bus_arbiter_checker #(
        .NrHosts (NrHosts),
        .IdxW    (IdxW)
    ) u_checker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .host_req_i   (host_req_i),
        .stall_i      (dev_req_o & ~dev_gnt_i),
        .sel_i        (sel_s),
        .dev_rvalid_i (dev_rvalid_i),
        .fifo_empty_i (fifo_empty_s),
        .fifo_full_i  (fifo_full_s),
        .push_i       (grant_s),
        .pop_i        (pop_s)
    );

endmodule
